mux_scan_nxw: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 26 ++
 rtl/mux_scan_if.sv | 38 +++
 rtl/mux_nxw_sel.sv | 20 ++
 rtl/mux_scan_nxw.sv | 112 +++++++++++
 tb/tb_mux_scan_nxw.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_nxw shared types: FSM state encoding and
// channel-index width helpers.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_w(input int n);
    int r;
    r = clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Sample-source / consumer bundle for mux_scan_nxw.
// The mux itself takes the slave side.
interface mux_scan_if #(
  parameter int N_CH = 64,
  parameter int W    = 1
);
  import mux_scan_pkg::*;

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH*W-1:0] in;
  logic              req_valid;
  logic [SEL_W-1:0]  req_sel;
  logic              req_ready;
  logic              start;
  logic [SEL_W-1:0]  scan_last;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output in, req_valid, req_sel,
    output start, scan_last, out_ready,
    input  req_ready, out_data, out_ch,
    input  out_valid, busy, done
  );

  modport slave (
    input  in, req_valid, req_sel,
    input  start, scan_last, out_ready,
    output req_ready, out_data, out_ch,
    output out_valid, busy, done
  );

endinterface

// File: rtl/mux_nxw_sel.sv
// Combinational N_CH x W selector; indices past
// the last channel yield zero.
module mux_nxw_sel #(
  parameter int N_CH  = 64,
  parameter int W     = 1,
  parameter int SEL_W = 6
) (
  input  logic [N_CH*W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      data
);

  always_comb begin
    data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == SEL_W'(c)) data = in[c*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_nxw.sv
// Registered N-channel mux with a one-deep output
// slot, manual requests and a 0..last scan engine.
module mux_scan_nxw
  import mux_scan_pkg::*;
#(
  parameter int N_CH = 64,
  parameter int W    = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_scan_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);
  localparam logic [SEL_W-1:0] MAXCH =
    SEL_W'(N_CH - 1);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ch_q;
  logic [W-1:0]     sel_data;
  logic [W-1:0]     data_q;
  logic             vld_q;
  logic             done_q;
  logic             slot_free;
  logic             rdy;
  logic             ld;

  assign slot_free = !vld_q | bus.out_ready;

  // start wins over a same-cycle manual request
  assign rdy = !rst && (state == IDLE) &&
               !bus.start && slot_free;

  always_comb begin
    ld  = 1'b0;
    sel = cnt;
    unique case (state)
      IDLE: begin
        ld  = bus.req_valid & rdy;
        sel = bus.req_sel;
      end
      SCAN:    ld = slot_free;
      default: ld = 1'b0;
    endcase
  end

  mux_nxw_sel #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_sel (
    .in   (bus.in),
    .sel  (sel),
    .data (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= '0;
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld) begin
        data_q <= sel_data;
        ch_q   <= sel;
        vld_q  <= 1'b1;
      end else if (vld_q && bus.out_ready) begin
        vld_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            last  <= (bus.scan_last > MAXCH) ?
                     MAXCH : bus.scan_last;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (slot_free) begin
            if (cnt == last) state <= DRAIN;
            else cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (vld_q && bus.out_ready) begin
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_scan_nxw.sv
// Directed bench for mux_scan_nxw: a 64x8 instance
// and a 48x8 instance for clamp/out-of-range cases.
module tb_mux_scan_nxw;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_scan_if #(.N_CH(64), .W(8)) b64 ();
  mux_scan_if #(.N_CH(48), .W(8)) b48 ();

  mux_scan_nxw #(.N_CH(64), .W(8)) u64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  mux_scan_nxw #(.N_CH(48), .W(8)) u48 (
    .clk (clk),
    .rst (rst),
    .bus (b48.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b64.start = 1'b1;
    b64.req_valid = 1'b1;
    b64.req_sel = 6'd3;
    step();
    step();
    checks++;
    if (b64.out_valid !== 1'b0 || b64.out_data !== 8'h00 ||
        b64.out_ch !== 6'd0) begin
      errors++;
      $display("FAIL reset_out: v=%b d=%h ch=%0d want 0 0 0",
               b64.out_valid, b64.out_data, b64.out_ch);
    end
    checks++;
    if (b64.busy !== 1'b0 || b64.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: busy=%b done=%b want 0 0",
               b64.busy, b64.done);
    end
    checks++;
    if (b64.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0",
               b64.req_ready);
    end
    rst = 1'b0;
    b64.start = 1'b0;
    b64.req_valid = 1'b0;
    step();
    checks++;
    if (b64.req_ready !== 1'b1 || b64.done !== 1'b0 ||
        b64.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rdy=%b done=%b busy=%b want 1 0 0",
               b64.req_ready, b64.done, b64.busy);
    end
  endtask

  task automatic test_manual();
    b64.out_ready = 1'b1;
    b64.req_valid = 1'b1;
    b64.req_sel = 6'd37;
    #1;
    checks++;
    if (b64.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL man_ready: got %b want 1", b64.req_ready);
    end
    step();
    checks++;
    if (b64.out_data !== 8'h65 || b64.out_ch !== 6'd37 ||
        b64.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL man_37: d=%h ch=%0d v=%b want 65 37 1",
               b64.out_data, b64.out_ch, b64.out_valid);
    end
    checks++;
    if (b64.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL man_b2b_ready: got %b want 1", b64.req_ready);
    end
    b64.req_sel = 6'd38;
    step();
    checks++;
    if (b64.out_data !== 8'h66 || b64.out_ch !== 6'd38 ||
        b64.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL man_38: d=%h ch=%0d v=%b want 66 38 1",
               b64.out_data, b64.out_ch, b64.out_valid);
    end
    b64.req_valid = 1'b0;
    step();
    checks++;
    if (b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL man_empty: v=%b want 0", b64.out_valid);
    end
  endtask

  task automatic test_backpressure();
    b64.out_ready = 1'b0;
    b64.req_valid = 1'b1;
    b64.req_sel = 6'd5;
    step();
    b64.req_sel = 6'd6;
    b64.in[5*8 +: 8] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b64.out_data !== 8'h45 || b64.out_ch !== 6'd5 ||
          b64.out_valid !== 1'b1 || b64.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: d=%h ch=%0d v=%b rdy=%b want 45 5 1 0",
                 i, b64.out_data, b64.out_ch, b64.out_valid,
                 b64.req_ready);
      end
    end
    b64.req_valid = 1'b0;
    b64.out_ready = 1'b1;
    #1;
    checks++;
    if (b64.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", b64.req_ready);
    end
    step();
    checks++;
    if (b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: v=%b want 0", b64.out_valid);
    end
    b64.in[5*8 +: 8] = 8'h45;
  endtask

  task automatic test_start_priority();
    b64.out_ready = 1'b1;
    b64.req_valid = 1'b1;
    b64.req_sel = 6'd9;
    b64.start = 1'b1;
    b64.scan_last = 6'd1;
    #1;
    checks++;
    if (b64.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got %b want 0", b64.req_ready);
    end
    step();
    b64.start = 1'b0;
    b64.req_valid = 1'b0;
    checks++;
    if (b64.busy !== 1'b1 || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_state: busy=%b v=%b want 1 0",
               b64.busy, b64.out_valid);
    end
    step();
    step();
    checks++;
    if (b64.out_ch !== 6'd1 || b64.out_data !== 8'h41) begin
      errors++;
      $display("FAIL prio_scan: ch=%0d d=%h want 1 41",
               b64.out_ch, b64.out_data);
    end
    step();
    checks++;
    if (b64.done !== 1'b1) begin
      errors++;
      $display("FAIL prio_done: got %b want 1", b64.done);
    end
  endtask

  task automatic test_scan();
    b64.out_ready = 1'b1;
    b64.scan_last = 6'd3;
    b64.start = 1'b1;
    step();
    b64.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (b64.out_ch !== 6'(i) || b64.out_valid !== 1'b1 ||
          b64.out_data !== 8'(i + 'h40) || b64.busy !== 1'b1 ||
          b64.done !== 1'b0) begin
        errors++;
        $display("FAIL scan_ch%0d: ch=%0d d=%h v=%b busy=%b done=%b",
                 i, b64.out_ch, b64.out_data, b64.out_valid,
                 b64.busy, b64.done);
      end
    end
    step();
    checks++;
    if (b64.done !== 1'b1 || b64.busy !== 1'b0 ||
        b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_done: done=%b busy=%b v=%b want 1 0 0",
               b64.done, b64.busy, b64.out_valid);
    end
    step();
    checks++;
    if (b64.done !== 1'b0) begin
      errors++;
      $display("FAIL scan_done_pulse: got %b want 0", b64.done);
    end
  endtask

  task automatic test_scan_zero();
    b64.out_ready = 1'b1;
    b64.scan_last = 6'd0;
    b64.start = 1'b1;
    step();
    b64.start = 1'b0;
    step();
    checks++;
    if (b64.out_ch !== 6'd0 || b64.out_valid !== 1'b1 ||
        b64.out_data !== 8'h40) begin
      errors++;
      $display("FAIL zero_ch0: ch=%0d v=%b d=%h want 0 1 40",
               b64.out_ch, b64.out_valid, b64.out_data);
    end
    step();
    checks++;
    if (b64.done !== 1'b1 || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b v=%b want 1 0",
               b64.done, b64.out_valid);
    end
  endtask

  task automatic test_scan_clamp();
    b48.out_ready = 1'b1;
    b48.scan_last = 6'd60;
    b48.start = 1'b1;
    step();
    b48.start = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      checks++;
      if (b48.out_ch !== 6'(i) || b48.out_valid !== 1'b1 ||
          b48.out_data !== 8'(i + 'h80)) begin
        errors++;
        $display("FAIL clamp_ch%0d: ch=%0d d=%h v=%b",
                 i, b48.out_ch, b48.out_data, b48.out_valid);
      end
    end
    step();
    checks++;
    if (b48.done !== 1'b1 || b48.out_valid !== 1'b0 ||
        b48.busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_done: done=%b v=%b busy=%b want 1 0 0",
               b48.done, b48.out_valid, b48.busy);
    end
  endtask

  task automatic test_toggle();
    int nxt;
    bit seen;
    nxt = 0;
    seen = 1'b0;
    b64.out_ready = 1'b1;
    b64.scan_last = 6'd7;
    b64.start = 1'b1;
    step();
    b64.start = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      b64.out_ready = cyc[0];
      @(negedge clk);
      if (b64.done) seen = 1'b1;
      if (b64.out_valid && b64.out_ready) begin
        checks++;
        if (b64.out_ch !== 6'(nxt) ||
            b64.out_data !== 8'(nxt + 'h40)) begin
          errors++;
          $display("FAIL toggle_seq: ch=%0d d=%h want ch %0d",
                   b64.out_ch, b64.out_data, nxt);
        end
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen || nxt != 8) begin
      errors++;
      $display("FAIL toggle_end: done_seen=%b count=%0d want 1 8",
               seen, nxt);
    end
    b64.out_ready = 1'b1;
    step();
  endtask

  task automatic test_rst_midscan();
    bit hit;
    hit = 1'b0;
    b64.out_ready = 1'b1;
    b64.scan_last = 6'd20;
    b64.start = 1'b1;
    step();
    b64.start = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (b64.out_valid && b64.out_ch == 6'd10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach10: got %b want 1", hit);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (b64.out_valid !== 1'b0 || b64.busy !== 1'b0 ||
        b64.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: v=%b busy=%b done=%b want 0 0 0",
               b64.out_valid, b64.busy, b64.done);
    end
    step();
    checks++;
    if (b64.done !== 1'b0 || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_after: done=%b v=%b want 0 0",
               b64.done, b64.out_valid);
    end
  endtask

  task automatic test_out_of_range();
    b48.out_ready = 1'b1;
    b48.req_valid = 1'b1;
    b48.req_sel = 6'd50;
    #1;
    checks++;
    if (b48.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready: got %b want 1", b48.req_ready);
    end
    step();
    b48.req_valid = 1'b0;
    checks++;
    if (b48.out_data !== 8'h00 || b48.out_ch !== 6'd50 ||
        b48.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL oor_load: d=%h ch=%0d v=%b want 00 50 1",
               b48.out_data, b48.out_ch, b48.out_valid);
    end
    step();
    checks++;
    if (b48.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_handshake: v=%b want 0", b48.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b64.req_valid = 1'b0;
    b64.req_sel = '0;
    b64.start = 1'b0;
    b64.scan_last = '0;
    b64.out_ready = 1'b1;
    b48.req_valid = 1'b0;
    b48.req_sel = '0;
    b48.start = 1'b0;
    b48.scan_last = '0;
    b48.out_ready = 1'b1;
    for (int c = 0; c < 64; c++) b64.in[c*8 +: 8] = 8'(c + 'h40);
    for (int c = 0; c < 48; c++) b48.in[c*8 +: 8] = 8'(c + 'h80);

    test_reset();
    test_manual();
    test_backpressure();
    test_start_priority();
    test_scan();
    test_scan_zero();
    test_scan_clamp();
    test_toggle();
    test_rst_midscan();
    test_out_of_range();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
